// File: rtl/alu_exec_unit.sv
// Execute-stage ALU consuming the 4-bit ALU control code; ALU_EXEC_FAST_SHIFT_EN selects a barrel shifter.
// Latency: 1 cycle for non-shift/illegal ops; shifts take max(shamt,1) cycles (1 with the fast build).
// Backpressure: result registers hold while out_valid && !out_ready; in_ready drops until the result is taken.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1101;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_illegal;

    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic               w_illegal;
    logic               w_accept;

    assign w_shamt   = op_b[SHAMT_W-1:0];
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_illegal;

`ifndef ALU_EXEC_FAST_SHIFT_EN
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic [3:0]         r_ctrl;
    logic [WIDTH-1:0]   w_step;
    logic               w_is_shift;

    function automatic logic [WIDTH-1:0] f_shift1(input logic [3:0] ctrl, input logic [WIDTH-1:0] v);
        case (ctrl)
            OP_SLL:  f_shift1 = {v[WIDTH-2:0], 1'b0};
            OP_SRA:  f_shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
            default: f_shift1 = {1'b0, v[WIDTH-1:1]};
        endcase
    endfunction

    assign w_step     = f_shift1(r_ctrl, r_work);
    assign w_is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    assign in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
`else
    assign in_ready   = !r_out_valid || out_ready;
`endif

    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_res     = '0;
        w_illegal = 1'b0;
        case (alu_ctrl)
            OP_AND: w_res = op_a & op_b;
            OP_OR:  w_res = op_a | op_b;
            OP_ADD: w_res = op_a + op_b;
            OP_XOR: w_res = op_a ^ op_b;
            OP_SUB: w_res = op_a - op_b;
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_EXEC_FAST_SHIFT_EN
            OP_SLL: w_res = op_a << w_shamt;
            OP_SRL: w_res = op_a >> w_shamt;
            OP_SRA: w_res = WIDTH'($signed(op_a) >>> w_shamt);
`else
            // The accept cycle performs the first single-bit step, so shamt cycles total.
            OP_SLL, OP_SRL, OP_SRA:
                    w_res = (w_shamt == '0) ? op_a : f_shift1(alu_ctrl, op_a);
`endif
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_illegal   <= 1'b0;
`ifndef ALU_EXEC_FAST_SHIFT_EN
            r_state     <= ST_IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_ctrl      <= '0;
`endif
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
`ifndef ALU_EXEC_FAST_SHIFT_EN
            if (r_state == ST_SHIFT) begin
                if (r_cnt == SHAMT_W'(1)) begin
                    r_result    <= w_step;
                    r_zero      <= (w_step == '0);
                    r_illegal   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end else begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt - SHAMT_W'(1);
                end
            end else
`endif
            if (w_accept) begin
`ifndef ALU_EXEC_FAST_SHIFT_EN
                if (w_is_shift && (w_shamt > SHAMT_W'(1))) begin
                    r_work  <= w_res;
                    r_cnt   <= w_shamt - SHAMT_W'(1);
                    r_ctrl  <= alu_ctrl;
                    r_state <= ST_SHIFT;
                end else
`endif
                begin
                    r_result    <= w_res;
                    r_zero      <= (w_res == '0);
                    r_illegal   <= w_illegal;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit against a behavioural operation model.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     alu_ctrl = 4'd0;
    logic [W-1:0]   op_a = '0;
    logic [W-1:0]   op_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   result;
    logic           zero;
    logic           illegal;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Returns {illegal, result}
    function automatic logic [W:0] model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        int sh;
        logic [W-1:0] ones;
        sh = int'(b[4:0]);
        ones = '1;
        case (c)
            4'd0:  return {1'b0, a & b};
            4'd1:  return {1'b0, a | b};
            4'd2:  return {1'b0, a + b};
            4'd4:  return {1'b0, a ^ b};
            4'd5:  return {1'b0, a << sh};
            4'd6:  return {1'b0, a - b};
            4'd7:  return {1'b0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
            4'd8:  return {1'b0, a >> sh};
            4'd13: return {1'b0, (a >> sh) | (a[W-1] ? ~(ones >> sh) : '0)};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    function automatic int model_lat(input logic [3:0] c, input logic [W-1:0] b);
`ifdef ALU_EXEC_FAST_SHIFT_EN
        return 1;
`else
        if (c == 4'd5 || c == 4'd8 || c == 4'd13)
            return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
        return 1;
`endif
    endfunction

    // Called at a falling edge; returns at the falling edge where the result is first visible.
    task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [W:0] exp;
        int elat;
        int lat;
        int waitc;
        exp  = model(c, a, b);
        elat = model_lat(c, b);
        waitc = 0;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s in_ready before issue: got %b want 1", name, in_ready);
        end
        alu_ctrl  = c;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (!out_valid && lat < 200) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s busy in_ready: got %b want 0 at cycle %0d", name, in_ready, lat);
                end
            end
        end while (!out_valid && lat < 200);
        n_cmp++;
        if (lat !== elat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
        end
        n_cmp++;
        if (result !== exp[W-1:0]) begin
            n_bad++;
            $display("FAIL %s result: got %h want %h", name, result, exp[W-1:0]);
        end
        n_cmp++;
        if (zero !== (exp[W-1:0] == '0)) begin
            n_bad++;
            $display("FAIL %s zero: got %b want %b", name, zero, (exp[W-1:0] == '0));
        end
        n_cmp++;
        if (illegal !== exp[W]) begin
            n_bad++;
            $display("FAIL %s illegal: got %b want %b", name, illegal, exp[W]);
        end
    endtask

    task automatic test_reset();
        #7;
        n_cmp++;
        if ({out_valid, result, zero, illegal, in_ready} !== {1'b0, {W{1'b0}}, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state: got ov=%b res=%h z=%b ill=%b rdy=%b want ov=0 res=0 z=1 ill=0 rdy=1",
                     out_valid, result, zero, illegal, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_sub();
        do_op(4'd2, 32'h7FFF_FFFF, 32'd1, "add_wrap");
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_in_ready: got %b want 1", in_ready);
        end
        do_op(4'd6, 32'd5, 32'd5, "sub_zero");
    endtask

    task automatic test_slt();
        do_op(4'd7, 32'hFFFF_FFFF, 32'd1, "slt_neg_pos");
        do_op(4'd7, 32'd1, 32'hFFFF_FFFF, "slt_pos_neg");
    endtask

    task automatic test_shifts();
        do_op(4'd13, 32'h8000_0000, 32'd4, "sra_4");
        do_op(4'd8,  32'h8000_0000, 32'd4, "srl_4");
        do_op(4'd5,  32'd1, 32'd31, "sll_31");
        do_op(4'd5,  32'h0000_1234, 32'h20, "sll_0");
        do_op(4'd13, 32'h8765_4321, 32'd1, "sra_1");
    endtask

    task automatic test_illegal();
        do_op(4'd3, 32'h1234_5678, 32'h9ABC_DEF0, "illegal_3");
        do_op(4'd0, 32'hFF00_FF00, 32'h0F0F_0F0F, "and_after_illegal");
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        alu_ctrl  = 4'd4;
        op_a      = 32'h0000_F0F0;
        op_b      = 32'h0000_0FF0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        alu_ctrl = 4'd2;
        op_a     = 32'd1;
        op_b     = 32'd1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'h0000_FF00}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got ov=%b rdy=%b res=%h want ov=1 rdy=0 res=0000ff00",
                         i, out_valid, in_ready, result);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, result, zero} !== {1'b1, 32'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_release: got ov=%b res=%h z=%b want ov=1 res=00000002 z=0", out_valid, result, zero);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midshift();
        logic stale;
        @(negedge clk);
        alu_ctrl  = 4'd5;
        op_a      = 32'h0000_0003;
        op_b      = 32'd10;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, result} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            n_bad++;
            $display("FAIL midshift_reset: got ov=%b rdy=%b res=%h want ov=0 rdy=1 res=0", out_valid, in_ready, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
        end
        n_cmp++;
        if (stale !== 1'b0) begin
            n_bad++;
            $display("FAIL midshift_stale: got stale=%b want 0", stale);
        end
        do_op(4'd2, 32'd2, 32'd3, "add_after_reset");
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            do_op(c, a, b, $sformatf("rand%0d_op%0d", i, c));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_slt();
        test_shifts();
        test_illegal();
        test_backpressure();
        test_reset_midshift();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
